seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Snapshots six active-low 7-segment patterns and presents each as a decoded hex digit over a valid/ready stream.
// Optional macro SEG7_DP_EN: store the DP bits and report a lit decimal point on digit_dp.
module seg7_scan_decoder (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [0:7] HEX0,
    input  logic [0:7] HEX1,
    input  logic [0:7] HEX2,
    input  logic [0:7] HEX3,
    input  logic [0:7] HEX4,
    input  logic [0:7] HEX5,
    input  logic       start,
    output logic       busy,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic [2:0] digit_index,
    output logic [3:0] digit_value,
    output logic       digit_err,
    output logic       digit_dp,
    output logic       done
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state_q;
    logic       busy_q, valid_q, err_q, dp_q, done_q;
    logic [2:0] index_q;
    logic [3:0] value_q;

    logic [0:7] hex_raw [6];
    logic [6:0] hex_seg [6];
    logic [6:0] seg_q   [6];

    assign hex_raw[0] = HEX0;
    assign hex_raw[1] = HEX1;
    assign hex_raw[2] = HEX2;
    assign hex_raw[3] = HEX3;
    assign hex_raw[4] = HEX4;
    assign hex_raw[5] = HEX5;

    // Bit 1 of each HEX word is segment g, so the slice lands g..a in bits 6..0.
    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
        assign hex_seg[gi] = hex_raw[gi][1:7];
    end

`ifdef SEG7_DP_EN
    logic hex_dp [6];
    logic dp_sh_q [6];
    for (genvar gi = 0; gi < 6; gi++) begin : g_dp
        assign hex_dp[gi] = hex_raw[gi][0];
    end
`else
    logic unused_dp;
    assign unused_dp = ^{hex_raw[0][0], hex_raw[1][0], hex_raw[2][0],
                         hex_raw[3][0], hex_raw[4][0], hex_raw[5][0]};
`endif

    // Returns {err, value}; unknown patterns decode to value 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    logic [2:0] index_d;
    logic [2:0] sel_d;
    logic [4:0] dec_d;
    logic       dp_d;

    // In IDLE the first digit is decoded straight from the live inputs being captured.
    always_comb begin
        index_d = index_q + 3'd1;
        sel_d   = (index_d > 3'd5) ? 3'd5 : index_d;
        dec_d   = (state_q == IDLE) ? decode(hex_seg[0]) : decode(seg_q[sel_d]);
`ifdef SEG7_DP_EN
        dp_d    = (state_q == IDLE) ? ~hex_dp[0] : ~dp_sh_q[sel_d];
`else
        dp_d    = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            index_q <= 3'd0;
            value_q <= 4'd0;
            err_q   <= 1'b0;
            dp_q    <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= 7'h7F;
`ifdef SEG7_DP_EN
                dp_sh_q[i] <= 1'b1;
`endif
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 6; i++) begin
                            seg_q[i] <= hex_seg[i];
`ifdef SEG7_DP_EN
                            dp_sh_q[i] <= hex_dp[i];
`endif
                        end
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        index_q <= 3'd0;
                        value_q <= dec_d[3:0];
                        err_q   <= dec_d[4];
                        dp_q    <= dp_d;
                    end
                end
                SCAN: begin
                    if (valid_q && digit_ready) begin
                        if (index_q == 3'd5) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            index_q <= 3'd0;
                            value_q <= 4'd0;
                            err_q   <= 1'b0;
                            dp_q    <= 1'b0;
                        end else begin
                            index_q <= index_d;
                            value_q <= dec_d[3:0];
                            err_q   <= dec_d[4];
                            dp_q    <= dp_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign digit_valid = valid_q;
    assign digit_index = index_q;
    assign digit_value = value_q;
    assign digit_err   = err_q;
    assign digit_dp    = dp_q;
    assign done        = done_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a table-lookup reference model.
module tb_seg7_scan_decoder;
    logic       CLOCK_50 = 1'b0;
    logic       reset, start, digit_ready;
    logic [0:7] hex [6];
    logic       busy, digit_valid, digit_err, digit_dp, done;
    logic [2:0] digit_index;
    logic [3:0] digit_value;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_scan_decoder dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .HEX0       (hex[0]),
        .HEX1       (hex[1]),
        .HEX2       (hex[2]),
        .HEX3       (hex[3]),
        .HEX4       (hex[4]),
        .HEX5       (hex[5]),
        .start      (start),
        .busy       (busy),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .digit_index(digit_index),
        .digit_value(digit_value),
        .digit_err  (digit_err),
        .digit_dp   (digit_dp),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {dp, err, value} for one HEX word, found by searching the digit table.
    function automatic logic [5:0] ref_digit(input logic [0:7] h);
        logic [6:0] seg;
        logic [5:0] r;
        seg = {h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
        r   = 6'b010000;
        for (int v = 0; v < 16; v++)
            if (seg_tbl[v] == seg) r = {2'b00, 4'(v)};
`ifdef SEG7_DP_EN
        r[5] = ~h[0];
`endif
        return r;
    endfunction

    // mode: 0 ready=1, 1 ready toggles 1/0, 2 ready low for 3 cycles, 3 random ready and start noise.
    task automatic run_scan(input int mode, input bit corrupt, input int abort_at);
        logic [0:7] snap [6];
        logic [5:0] exp;
        int idx, cyc;
        @(negedge CLOCK_50);
        snap = hex;
        start = 1'b1;
        digit_ready = 1'b0;
        @(negedge CLOCK_50);
        start = 1'b0;
        if (corrupt) for (int i = 0; i < 6; i++) hex[i] = 8'h80;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 200) begin
            exp = ref_digit(snap[idx]);
            check("valid", digit_valid, 1);
            check("busy", busy, 1);
            check("done_low", done, 0);
            check("index", digit_index, idx);
            check("value", digit_value, exp[3:0]);
            check("err", digit_err, exp[4]);
            check("dp", digit_dp, exp[5]);
            if (idx == abort_at) begin
                reset = 1'b1;
                digit_ready = 1'b1;
                @(posedge CLOCK_50);
                @(negedge CLOCK_50);
                reset = 1'b0;
                digit_ready = 1'b0;
                check("rst_valid", digit_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_index", digit_index, 0);
                $display("reset during scan at index %0d", idx);
                return;
            end
            case (mode)
                0:       digit_ready = 1'b1;
                1:       digit_ready = (cyc % 2 == 0);
                2:       digit_ready = (cyc >= 3);
                default: digit_ready = 1'($urandom % 2);
            endcase
            start = (mode == 3) ? 1'($urandom % 2) : (idx == 5);
            @(posedge CLOCK_50);
            if (digit_ready) begin
                $display("xfer idx=%0d value=%h err=%0d dp=%0d", idx, exp[3:0], exp[4], exp[5]);
                idx++;
            end
            cyc++;
            @(negedge CLOCK_50);
        end
        start = 1'b0;
        digit_ready = 1'b0;
        if (idx < 6) begin
            check("timeout", idx, 6);
        end else begin
            check("done_pulse", done, 1);
            check("end_valid", digit_valid, 0);
            check("end_busy", busy, 0);
            @(negedge CLOCK_50);
            check("done_once", done, 0);
            check("no_restart", digit_valid, 0);
        end
    endtask

    task automatic set_hex(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] e, input logic [7:0] f);
        hex[0] = a; hex[1] = b; hex[2] = c; hex[3] = d; hex[4] = e; hex[5] = f;
    endtask

    initial begin
        logic [6:0] s;
        reset = 1'b1;
        start = 1'b1;
        digit_ready = 1'b0;
        set_hex(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        start = 1'b0;
        check("r_valid", digit_valid, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        check("r_index", digit_index, 0);
        check("r_value", digit_value, 0);
        check("r_err", digit_err, 0);
        check("r_dp", digit_dp, 0);
        @(negedge CLOCK_50);
        check("r_idle", digit_valid, 0);

        set_hex(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
        run_scan(0, 1'b0, -1);

        set_hex(8'hC0, 8'hC0, 8'hFF, 8'hC0, 8'hC0, 8'hC0);
        run_scan(1, 1'b0, -1);

        set_hex(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
        run_scan(2, 1'b1, -1);

        set_hex(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
        run_scan(0, 1'b0, 3);
        run_scan(0, 1'b0, -1);

        set_hex(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h79, 8'hC0);
        run_scan(0, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 6; i++) begin
                s = seg_tbl[$urandom_range(0, 15)];
                if ($urandom % 2) hex[i] = {1'($urandom % 2), s};
                else              hex[i] = 8'($urandom);
            end
            run_scan(3, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
